// File: rtl/fifo_sync_v2_pkg.sv
// fifo_pkg: shared read-mode type and width helpers for fifo_sync_v2
package fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_sync_v2_if.sv
// fifo_sync_v2_if: producer/consumer bus of fifo_sync_v2; parity_err present with FIFO_SYNC_V2_PARITY_EN
interface fifo_sync_v2_if #(parameter int DEPTH = 8, parameter int WIDTH = 32);
  logic we, re, rvalid, full, almost_full, empty, almost_empty, overflow, underflow;
  logic [WIDTH-1:0] wdata, rdata;
  logic [fifo_pkg::fifo_cw(DEPTH)-1:0] count;
`ifdef FIFO_SYNC_V2_PARITY_EN
  logic parity_err;
  modport master (output we, wdata, re, input rdata, rvalid, full, almost_full, empty, almost_empty, count, overflow, underflow, parity_err);
  modport slave (input we, wdata, re, output rdata, rvalid, full, almost_full, empty, almost_empty, count, overflow, underflow, parity_err);
`else
  modport master (output we, wdata, re, input rdata, rvalid, full, almost_full, empty, almost_empty, count, overflow, underflow);
  modport slave (input we, wdata, re, output rdata, rvalid, full, almost_full, empty, almost_empty, count, overflow, underflow);
`endif
endinterface

// File: rtl/fifo_sync_v2_ptr_wrap.sv
// fifo_ptr_wrap: pointer counter that wraps from DEPTH-1 to 0 for any DEPTH
module fifo_ptr_wrap import fifo_pkg::*; #(parameter int DEPTH = 8) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic [fifo_aw(DEPTH)-1:0] ptr
);
  localparam int AW = fifo_aw(DEPTH);
  // advance on each accepted operation, explicit wrap for non-power-of-two depths
  always_ff @(posedge clk)
    if (!rst) ptr <= '0;
    else if (inc) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/fifo_sync_v2.sv
// fifo_sync_v2: single-clock FIFO, any depth, STD/FWFT read; FIFO_SYNC_V2_PARITY_EN adds stored parity and parity_err
module fifo_sync_v2 import fifo_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter fifo_mode_e MODE = FIFO_STD
) (
  input logic clk,
  input logic rst,
  fifo_sync_v2_if.slave bus
);
  localparam int AW = fifo_aw(DEPTH);
  localparam int CW = fifo_cw(DEPTH);
`ifdef FIFO_SYNC_V2_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_param
    $error("fifo_sync_v2: illegal DEPTH/AF_THRESH/AE_THRESH");
  end
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] head, wentry;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic wr_ok, rd_ok, full, empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr_ok = bus.we && !full;
  assign rd_ok = bus.re && !empty;
  assign head = mem[rptr];
`ifdef FIFO_SYNC_V2_PARITY_EN
  assign wentry = {^bus.wdata, bus.wdata};
`else
  assign wentry = bus.wdata;
`endif
  assign bus.count = count;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.almost_full = count >= CW'(AF_THRESH);
  assign bus.almost_empty = count <= CW'(AE_THRESH);
  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wptr (.clk(clk), .rst(rst), .inc(wr_ok), .ptr(wptr));
  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rptr (.clk(clk), .rst(rst), .inc(rd_ok), .ptr(rptr));
  // storage is deliberately not reset
  always_ff @(posedge clk)
    if (wr_ok) mem[wptr] <= wentry;
  // occupancy and rejected-request pulses
  always_ff @(posedge clk)
    if (!rst) begin
      count <= '0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      count <= (wr_ok && !rd_ok) ? count + 1'b1 : (rd_ok && !wr_ok) ? count - 1'b1 : count;
      bus.overflow <= bus.we && full;
      bus.underflow <= bus.re && empty;
    end
  if (MODE == FIFO_STD) begin : g_std
    logic [WIDTH-1:0] rdata_q;
    logic rvalid_q;
    // registered read: data captured on the accepted pop, valid for one cycle
    always_ff @(posedge clk)
      if (!rst) begin
        rdata_q <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_ok;
        if (rd_ok) rdata_q <= head[WIDTH-1:0];
      end
    assign bus.rdata = rdata_q;
    assign bus.rvalid = rvalid_q;
`ifdef FIFO_SYNC_V2_PARITY_EN
    logic perr_q;
    // parity check registered alongside the read data
    always_ff @(posedge clk)
      if (!rst) perr_q <= 1'b0;
      else perr_q <= rd_ok && ^head;
    assign bus.parity_err = perr_q;
`endif
  end else begin : g_fwft
    assign bus.rvalid = !empty;
    assign bus.rdata = empty ? '0 : head[WIDTH-1:0];
`ifdef FIFO_SYNC_V2_PARITY_EN
    assign bus.parity_err = !empty && ^head;
`endif
  end
endmodule

// File: tb/tb_fifo_sync_v2.sv
// tb_fifo_sync_v2: directed checks of fifo_sync_v2 in STD and FWFT modes (parity case with FIFO_SYNC_V2_PARITY_EN)
module tb_fifo_sync_v2;
  import fifo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fifo_sync_v2_if #(.DEPTH(6), .WIDTH(8)) s ();
  fifo_sync_v2_if #(.DEPTH(6), .WIDTH(8)) f ();
  fifo_sync_v2 #(.DEPTH(6), .WIDTH(8), .AF_THRESH(5), .AE_THRESH(1), .MODE(FIFO_STD)) u_std (.clk(clk), .rst(rst), .bus(s.slave));
  fifo_sync_v2 #(.DEPTH(6), .WIDTH(8), .AF_THRESH(5), .AE_THRESH(1), .MODE(FIFO_FWFT)) u_fw (.clk(clk), .rst(rst), .bus(f.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    s.we = 1'b1;
    s.wdata = d;
    tick();
    s.we = 1'b0;
  endtask
  task automatic rd(input logic [7:0] exp);
    s.re = 1'b1;
    tick();
    s.re = 1'b0;
    chk("std_rvalid", 32'(s.rvalid), 1);
    chk("std_rdata", 32'(s.rdata), 32'(exp));
  endtask
  initial begin
    s.we = 0; s.re = 0; s.wdata = '0;
    f.we = 0; f.re = 0; f.wdata = '0;
    tick();
    chk("rst_count", 32'(s.count), 0);
    chk("rst_empty", 32'(s.empty), 1);
    chk("rst_ae", 32'(s.almost_empty), 1);
    chk("rst_full", 32'(s.full), 0);
    chk("rst_af", 32'(s.almost_full), 0);
    chk("rst_rvalid", 32'(s.rvalid), 0);
    chk("rst_rdata", 32'(s.rdata), 0);
    chk("rst_ovf", 32'(s.overflow), 0);
    chk("rst_unf", 32'(s.underflow), 0);
    chk("rst_fw_rvalid", 32'(f.rvalid), 0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr(8'(8'h11 + i));
      chk("t1_count", 32'(s.count), 32'(i + 1));
      chk("t1_af", 32'(s.almost_full), (i >= 4) ? 1 : 0);
      chk("t1_ae", 32'(s.almost_empty), (i == 0) ? 1 : 0);
    end
    chk("t1_full", 32'(s.full), 1);
    wr(8'h17);
    chk("t1_ovf", 32'(s.overflow), 1);
    chk("t1_ovf_count", 32'(s.count), 6);
    tick();
    chk("t1_ovf_clr", 32'(s.overflow), 0);
    for (int i = 0; i < 6; i++) begin
      rd(8'(8'h11 + i));
      tick();
      chk("t2_rvalid_pulse", 32'(s.rvalid), 0);
    end
    chk("t2_empty", 32'(s.empty), 1);
    s.re = 1'b1;
    tick();
    s.re = 1'b0;
    chk("t2_unf", 32'(s.underflow), 1);
    chk("t2_unf_rvalid", 32'(s.rvalid), 0);
    chk("t2_hold", 32'(s.rdata), 32'h16);
    tick();
    chk("t2_unf_clr", 32'(s.underflow), 0);
    for (int i = 0; i < 4; i++) wr(8'(8'h31 + i));
    for (int i = 0; i < 4; i++) rd(8'(8'h31 + i));
    for (int i = 0; i < 6; i++) wr(8'(8'h21 + i));
    chk("t3_full", 32'(s.full), 1);
    chk("t3_count", 32'(s.count), 6);
    for (int i = 0; i < 6; i++) rd(8'(8'h21 + i));
    chk("t3_empty", 32'(s.empty), 1);
    for (int i = 0; i < 3; i++) wr(8'(8'h41 + i));
    for (int i = 0; i < 4; i++) begin
      s.we = 1'b1;
      s.wdata = 8'(8'h44 + i);
      s.re = 1'b1;
      tick();
      s.we = 1'b0;
      s.re = 1'b0;
      chk("t4_sim_count", 32'(s.count), 3);
      chk("t4_sim_rdata", 32'(s.rdata), 32'(8'h41 + i));
    end
    for (int i = 0; i < 3; i++) rd(8'(8'h45 + i));
    chk("t4_empty", 32'(s.empty), 1);
    s.we = 1'b1;
    s.wdata = 8'h50;
    s.re = 1'b1;
    tick();
    s.we = 1'b0;
    s.re = 1'b0;
    chk("t4_e_count", 32'(s.count), 1);
    chk("t4_e_unf", 32'(s.underflow), 1);
    chk("t4_e_rvalid", 32'(s.rvalid), 0);
    rd(8'h50);
    f.we = 1'b1;
    f.wdata = 8'hA5;
    tick();
    f.we = 1'b0;
    chk("t5_empty", 32'(f.empty), 0);
    chk("t5_rvalid", 32'(f.rvalid), 1);
    chk("t5_rdata", 32'(f.rdata), 32'hA5);
    f.re = 1'b1;
    tick();
    f.re = 1'b0;
    chk("t5_pop_empty", 32'(f.empty), 1);
    chk("t5_pop_rvalid", 32'(f.rvalid), 0);
    f.we = 1'b1;
    f.wdata = 8'hB1;
    tick();
    f.wdata = 8'hB2;
    tick();
    f.we = 1'b0;
    chk("t5_head1", 32'(f.rdata), 32'hB1);
    f.re = 1'b1;
    tick();
    f.re = 1'b0;
    chk("t5_head2", 32'(f.rdata), 32'hB2);
    chk("t5_count", 32'(f.count), 1);
    for (int i = 0; i < 4; i++) wr(8'(8'h61 + i));
    chk("t6_pre_count", 32'(s.count), 4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_count", 32'(s.count), 0);
    chk("t6_empty", 32'(s.empty), 1);
    chk("t6_ae", 32'(s.almost_empty), 1);
    chk("t6_rvalid", 32'(s.rvalid), 0);
    chk("t6_fw_empty", 32'(f.empty), 1);
    s.re = 1'b1;
    tick();
    s.re = 1'b0;
    chk("t6_unf", 32'(s.underflow), 1);
`ifdef FIFO_SYNC_V2_PARITY_EN
    wr(8'h3C);
    wr(8'h5A);
    u_std.mem[0][0] = ~u_std.mem[0][0];
    rd(8'h3D);
    chk("par_err_hit", 32'(s.parity_err), 1);
    tick();
    chk("par_err_clr", 32'(s.parity_err), 0);
    rd(8'h5A);
    chk("par_err_clean", 32'(s.parity_err), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_sync_v2.md
Name: fifo_sync_v2

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Supports any DEPTH ≥ 2, not only powers of two.
- Adds an explicit occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow pulses, and a selectable registered or first-word-fall-through (FWFT) read mode.
- Used as the general buffering element between streaming producer/consumer blocks in one clock domain.

Parameters:
- DEPTH, 8: number of entries; ≥ 2; any integer.
- WIDTH, 32: data width in bits.
- AF_THRESH, DEPTH-1: almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- MODE, FIFO_STD: read mode, type fifo_mode_e; FIFO_STD = registered read, FIFO_FWFT = fall-through.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- we  in  1  write request.
- wdata  in  WIDTH  write data.
- re  in  1  read request (pop).
- rdata  out  WIDTH  read data.
- rvalid  out  1  rdata valid.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_THRESH.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  one-cycle pulse: we while full.
- underflow  out  1  one-cycle pulse: re while empty.

Behaviour:
- Reset/clocking: one clock, clk. Reset is synchronous and active-low on rst; it is sampled only on the clk posedge.
- Reset values (next edge with rst=0):
  - wptr = 0, rptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
  - Storage array is not reset.
- Reset mid-operation: all contents are discarded; every output takes its reset value on that edge.
- Accept rules: a write is accepted iff we && !full; a read is accepted iff re && !empty. Flags are evaluated from the registered count.
- Rejected requests: no state change, except overflow (we && full) or underflow (re && empty) pulses high the next cycle for one cycle.
- Pointers: advance by one per accepted operation; explicit wrap from DEPTH-1 to 0. Pointer width is $clog2(DEPTH).
- Count: +1 on write only, -1 on read only, unchanged on simultaneous accepted write+read.
- Simultaneous requests:
  - we && re when empty: write accepted, read rejected, underflow pulses, count becomes 1.
  - we && re when full: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
- Flags: combinational decode of the count register only; no other combinational input paths.
- FIFO_STD read path:
  - rdata <= mem[rptr] on an accepted read; rvalid pulses 1 in the following cycle.
  - rdata holds its last value otherwise.
  - Write-to-readable latency is 1 cycle (empty drops the edge after the write).
- FIFO_FWFT read path:
  - rdata = mem[rptr] and rvalid = !empty, combinationally.
  - re acknowledges and pops the head; the next head appears the cycle after the pop.
  - First write becomes visible one cycle after the write edge.
- Parameter checks: an elaboration-time error is raised for DEPTH < 2 or AF_THRESH/AE_THRESH out of range.

Optional Feature:
- Macro: FIFO_SYNC_V2_PARITY_EN.
- Defined:
  - Storage is WIDTH+1 bits; the extra bit is even parity ^wdata, written alongside the data.
  - Extra output parity_err (1 bit) is recomputed on the read data, with reset value 0.
  - parity_err is aligned with rvalid: the registered cycle in FIFO_STD; combinational while rvalid in FIFO_FWFT.
  - It asserts on a parity mismatch.
- Undefined: no parity bit stored, no parity_err port; behaviour otherwise identical.

Decomposition:
- Package fifo_pkg:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}.
  - Function fifo_aw(depth), returning the pointer width.
  - Function fifo_cw(depth), returning the count width.
- Sub-module fifo_ptr_wrap:
  - Parameter DEPTH; inputs clk, rst, inc; output ptr.
  - Wrapping pointer counter; instanced twice (write and read).

Test Plan:
1. DEPTH=6, WIDTH=8, AF=5, AE=1, STD; write 0x11..0x16 → almost_full the cycle after the 5th write; full and count=6 after the 6th. A 7th write → overflow pulse, count stays 6.
2. Continue from 1: read 6 times → rdata 0x11..0x16 in order, each with a one-cycle rvalid after its re. empty after the last read; an extra re → underflow pulse, rdata holds 0x16.
3. Wrap: write 4, read 4, then write 6 (0x21..0x26) → full, both pointers have wrapped past 5→0, reads return 0x21..0x26 in order.
4. Simultaneous: at count=3, we+re for 4 cycles → count stays 3, FIFO order preserved. At count=0, we+re → count=1 and underflow pulse.
5. FWFT: write 0xA5 → the next cycle shows empty=0, rvalid=1, rdata=0xA5 with no re. re → the next cycle shows empty=1, rvalid=0.
6. Reset at count=4 (rst=0 for one edge) → count=0, empty=1, almost_empty=1, rvalid=0. A following re → underflow. With FIFO_SYNC_V2_PARITY_EN, a bench deposit flipping a stored bit → parity_err=1 on that read only.
